// File: rtl/operand_feeder_pkg.sv
// Shared types and constants for the A/W operand feeder and its per-channel datapath.
package operand_feeder_pkg;

  localparam int DW    = 128;
  localparam int LANES = 4;
  localparam int AW    = 10;
  localparam int CNTW  = 12;

  typedef enum logic [1:0] {
    CH_IDLE,
    CH_FETCH,
    CH_FULL,
    CH_DRAIN
  } ch_state_t;

endpackage

// File: rtl/operand_feeder_channel.sv
// One operand channel: walks one SRAM port, assembles LANES words in staging and presents
// them on registered lanes under the downstream busy handshake.
module operand_channel
  import operand_feeder_pkg::*;
#(
  parameter int DW   = operand_feeder_pkg::DW,
  parameter int AW   = operand_feeder_pkg::AW,
  parameter int CNTW = operand_feeder_pkg::CNTW
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [AW-1:0]              base,
  input  logic [CNTW-1:0]            num_beats,
  input  logic                       stall,
  output logic                       rd_en,
  output logic [AW-1:0]              rd_addr,
  input  logic [DW-1:0]              rd_data,
  output logic [LANES-1:0][DW-1:0]   src,
  output logic                       vld,
  output logic                       idle
);

  ch_state_t                 state;
  logic [2:0]                issued;
  logic [CNTW-1:0]           beat;
  logic [CNTW-1:0]           next_beat;
  logic [AW-1:0]             off;
  logic [AW-1:0]             issue_off;
  logic [1:0]                issue_lane;
  logic                      rd_pend;
  logic [1:0]                ret_lane;
  logic [LANES-1:0][DW-1:0]  staging;
  logic                      more_beats;

  assign next_beat  = beat + CNTW'(1);
  assign more_beats = (next_beat < num_beats);
  assign idle       = (state == CH_IDLE);

  // The first read of the next beat goes out in the same cycle the full staging is
  // handed to the output lanes, so its data lands only after staging has emptied.
  always_comb begin
    rd_en      = 1'b0;
    issue_off  = off;
    issue_lane = issued[1:0];
    if (state == CH_FETCH && issued != 3'd4) begin
      rd_en = 1'b1;
    end else if (state == CH_FULL && !stall && more_beats) begin
      rd_en      = 1'b1;
      issue_off  = off + AW'(4);
      issue_lane = 2'd0;
    end
    rd_addr = base + issue_off + AW'(issue_lane);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= CH_IDLE;
      issued   <= '0;
      beat     <= '0;
      off      <= '0;
      rd_pend  <= 1'b0;
      ret_lane <= '0;
      staging  <= '0;
      src      <= '0;
      vld      <= 1'b0;
    end else begin
      rd_pend  <= rd_en;
      ret_lane <= issue_lane;
      if (rd_pend) begin
        staging[ret_lane] <= rd_data;
      end

      if (!stall) begin
        if (state == CH_FULL) begin
          src <= staging;
          vld <= 1'b1;
        end else begin
          vld <= 1'b0;
        end
      end

      case (state)
        CH_IDLE: begin
          if (start) begin
            state  <= CH_FETCH;
            issued <= '0;
            beat   <= '0;
            off    <= '0;
          end
        end
        CH_FETCH: begin
          if (rd_en) begin
            issued <= issued + 3'd1;
          end
          if (rd_pend && ret_lane == 2'd3) begin
            state <= CH_FULL;
          end
        end
        CH_FULL: begin
          if (!stall) begin
            if (more_beats) begin
              state  <= CH_FETCH;
              beat   <= next_beat;
              off    <= off + AW'(4);
              issued <= 3'd1;
            end else begin
              state <= CH_DRAIN;
            end
          end
        end
        CH_DRAIN: begin
          if (!stall) begin
            state <= CH_IDLE;
          end
        end
        default: state <= CH_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/operand_feeder.sv
// Producer side of the A/W operand buffer handshake: latches a transfer request, runs the
// two operand channels independently and reports completion once both have drained.
module operand_feeder
  import operand_feeder_pkg::*;
#(
  parameter int DW   = operand_feeder_pkg::DW,
  parameter int AW   = operand_feeder_pkg::AW,
  parameter int CNTW = operand_feeder_pkg::CNTW
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [AW-1:0]    i_base_A,
  input  logic [AW-1:0]    i_base_W,
  input  logic [CNTW-1:0]  i_num_beats,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_rd_en_A,
  output logic             o_rd_en_W,
  output logic [AW-1:0]    o_rd_addr_A,
  output logic [AW-1:0]    o_rd_addr_W,
  input  logic [DW-1:0]    i_rd_data_A,
  input  logic [DW-1:0]    i_rd_data_W,
  input  logic             i_busy_A,
  input  logic             i_busy_W,
  output logic [DW-1:0]    o_src_A_0,
  output logic [DW-1:0]    o_src_A_1,
  output logic [DW-1:0]    o_src_A_2,
  output logic [DW-1:0]    o_src_A_3,
  output logic [DW-1:0]    o_src_W_0,
  output logic [DW-1:0]    o_src_W_1,
  output logic [DW-1:0]    o_src_W_2,
  output logic [DW-1:0]    o_src_W_3,
  output logic             o_vld_A,
  output logic             o_vld_W
);

  logic                      go;
  logic [AW-1:0]             base_a_q;
  logic [AW-1:0]             base_w_q;
  logic [CNTW-1:0]           num_q;
  logic                      idle_a;
  logic                      idle_w;
  logic [LANES-1:0][DW-1:0]  src_a;
  logic [LANES-1:0][DW-1:0]  src_w;

  assign go = i_start && !o_busy && (i_num_beats != '0);

  // Zero-beat requests complete immediately without ever raising o_busy.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      base_a_q <= '0;
      base_w_q <= '0;
      num_q    <= '0;
    end else begin
      o_done <= 1'b0;
      if (i_start && !o_busy) begin
        base_a_q <= i_base_A;
        base_w_q <= i_base_W;
        num_q    <= i_num_beats;
        if (i_num_beats == '0) begin
          o_done <= 1'b1;
        end else begin
          o_busy <= 1'b1;
        end
      end else if (o_busy && idle_a && idle_w) begin
        o_busy <= 1'b0;
        o_done <= 1'b1;
      end
    end
  end

  operand_channel #(.DW(DW), .AW(AW), .CNTW(CNTW)) u_chan_a (
    .clk       (i_clk),
    .rst       (i_rst),
    .start     (go),
    .base      (base_a_q),
    .num_beats (num_q),
    .stall     (i_busy_A),
    .rd_en     (o_rd_en_A),
    .rd_addr   (o_rd_addr_A),
    .rd_data   (i_rd_data_A),
    .src       (src_a),
    .vld       (o_vld_A),
    .idle      (idle_a)
  );

  operand_channel #(.DW(DW), .AW(AW), .CNTW(CNTW)) u_chan_w (
    .clk       (i_clk),
    .rst       (i_rst),
    .start     (go),
    .base      (base_w_q),
    .num_beats (num_q),
    .stall     (i_busy_W),
    .rd_en     (o_rd_en_W),
    .rd_addr   (o_rd_addr_W),
    .rd_data   (i_rd_data_W),
    .src       (src_w),
    .vld       (o_vld_W),
    .idle      (idle_w)
  );

  assign o_src_A_0 = src_a[0];
  assign o_src_A_1 = src_a[1];
  assign o_src_A_2 = src_a[2];
  assign o_src_A_3 = src_a[3];
  assign o_src_W_0 = src_w[0];
  assign o_src_W_1 = src_w[1];
  assign o_src_W_2 = src_w[2];
  assign o_src_W_3 = src_w[3];

endmodule

// File: tb/tb_operand_feeder.sv
// Randomized bench for operand_feeder: SRAM models, a capture monitor and a
// scoreboard built from the address/beat rules of the transfer.
module tb_operand_feeder;

  localparam int DW   = 128;
  localparam int AW   = 10;
  localparam int CNTW = 12;
  localparam int MEMN = 1024;

  typedef logic [4*DW-1:0] beat_t;

  logic            i_clk = 1'b0;
  logic            i_rst = 1'b1;
  logic            i_start = 1'b0;
  logic [AW-1:0]   i_base_A = '0;
  logic [AW-1:0]   i_base_W = '0;
  logic [CNTW-1:0] i_num_beats = '0;
  logic            o_busy, o_done;
  logic            o_rd_en_A, o_rd_en_W;
  logic [AW-1:0]   o_rd_addr_A, o_rd_addr_W;
  logic [DW-1:0]   i_rd_data_A = '0;
  logic [DW-1:0]   i_rd_data_W = '0;
  logic            i_busy_A = 1'b0;
  logic            i_busy_W = 1'b0;
  logic [DW-1:0]   o_src_A_0, o_src_A_1, o_src_A_2, o_src_A_3;
  logic [DW-1:0]   o_src_W_0, o_src_W_1, o_src_W_2, o_src_W_3;
  logic            o_vld_A, o_vld_W;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [DW-1:0] mem_a [MEMN];
  logic [DW-1:0] mem_w [MEMN];

  beat_t         cap_a[$], cap_w[$];
  int            cap_a_edge[$], cap_w_edge[$];
  logic [AW-1:0] rd_a[$], rd_w[$];
  int            rd_a_edge[$];
  int            done_q[$];
  logic          done_busy_q[$];
  bit            busy_seen;
  int            rise_a, rise_w;

  operand_feeder dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
    .i_base_A(i_base_A), .i_base_W(i_base_W), .i_num_beats(i_num_beats),
    .o_busy(o_busy), .o_done(o_done),
    .o_rd_en_A(o_rd_en_A), .o_rd_en_W(o_rd_en_W),
    .o_rd_addr_A(o_rd_addr_A), .o_rd_addr_W(o_rd_addr_W),
    .i_rd_data_A(i_rd_data_A), .i_rd_data_W(i_rd_data_W),
    .i_busy_A(i_busy_A), .i_busy_W(i_busy_W),
    .o_src_A_0(o_src_A_0), .o_src_A_1(o_src_A_1), .o_src_A_2(o_src_A_2), .o_src_A_3(o_src_A_3),
    .o_src_W_0(o_src_W_0), .o_src_W_1(o_src_W_1), .o_src_W_2(o_src_W_2), .o_src_W_3(o_src_W_3),
    .o_vld_A(o_vld_A), .o_vld_W(o_vld_W)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    cyc <= cyc + 1;
    if (o_rd_en_A) i_rd_data_A <= mem_a[o_rd_addr_A];
    if (o_rd_en_W) i_rd_data_W <= mem_w[o_rd_addr_W];
  end

  // A beat counts as delivered when o_vld is high and busy is low going into the next edge.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_vld_A && !i_busy_A) begin
        cap_a.push_back({o_src_A_3, o_src_A_2, o_src_A_1, o_src_A_0});
        cap_a_edge.push_back(cyc + 1);
      end
      if (o_vld_W && !i_busy_W) begin
        cap_w.push_back({o_src_W_3, o_src_W_2, o_src_W_1, o_src_W_0});
        cap_w_edge.push_back(cyc + 1);
      end
      if (o_rd_en_A) begin
        rd_a.push_back(o_rd_addr_A);
        rd_a_edge.push_back(cyc + 1);
      end
      if (o_rd_en_W) rd_w.push_back(o_rd_addr_W);
      if (o_done) begin
        done_q.push_back(cyc);
        done_busy_q.push_back(o_busy);
      end
      if (o_busy) busy_seen = 1'b1;
      if (o_vld_A && rise_a < 0) rise_a = cyc;
      if (o_vld_W && rise_w < 0) rise_w = cyc;
    end
  end

  function automatic beat_t exp_beat(input bit ch_w, input logic [AW-1:0] base, input int b);
    beat_t r;
    int    a;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      a = (int'(base) + 4 * b + k) % MEMN;
      r[k*DW +: DW] = ch_w ? mem_w[a] : mem_a[a];
    end
    return r;
  endfunction

  task automatic clear_logs();
    cap_a.delete(); cap_w.delete(); cap_a_edge.delete(); cap_w_edge.delete();
    rd_a.delete(); rd_w.delete(); rd_a_edge.delete();
    done_q.delete(); done_busy_q.delete();
    busy_seen = 1'b0;
    rise_a = -1;
    rise_w = -1;
  endtask

  task automatic do_start(input logic [AW-1:0] ba, input logic [AW-1:0] bw,
                          input logic [CNTW-1:0] n, output int s);
    @(posedge i_clk); #1;
    i_base_A = ba; i_base_W = bw; i_num_beats = n; i_start = 1'b1;
    s = cyc + 1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
  endtask

  task automatic run_until_done(input int budget, input int pct_a, input int pct_w,
                                input int win_lo, input int win_hi, output bit timed_out);
    int extra;
    extra = -1;
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(posedge i_clk); #1;
      i_busy_A = ((cyc + 1 >= win_lo) && (cyc + 1 <= win_hi)) || (int'($urandom_range(99)) < pct_a);
      i_busy_W = (int'($urandom_range(99)) < pct_w);
      if (done_q.size() > 0 && extra < 0) begin
        extra = 4;
        timed_out = 1'b0;
      end
      if (extra == 0) break;
      if (extra > 0) extra--;
    end
    i_busy_A = 1'b0;
    i_busy_W = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    total++;
    if ({o_busy, o_done, o_rd_en_A, o_rd_en_W, o_rd_addr_A, o_rd_addr_W, o_vld_A, o_vld_W} !== '0)
      begin bad++; $display("[TB] FAIL reset_ctrl: got nonzero control outputs, expected 0"); end
    total++;
    if ({o_src_A_0, o_src_A_1, o_src_A_2, o_src_A_3, o_src_W_0, o_src_W_1, o_src_W_2, o_src_W_3} !== '0)
      begin bad++; $display("[TB] FAIL reset_src: got nonzero lanes, expected 0"); end
    i_rst = 1'b0;
  endtask

  task automatic test_single_beat();
    int s;
    bit to;
    clear_logs();
    do_start(10'h010, 10'h200, 12'd1, s);
    run_until_done(100, 0, 0, -1, -1, to);
    total++;
    if (to) begin bad++; $display("[TB] FAIL single_timeout: got no o_done, expected one"); end
    total++;
    if (rd_a.size() != 4 || rd_w.size() != 4)
      begin bad++; $display("[TB] FAIL single_nreads: got A=%0d W=%0d, expected 4/4", rd_a.size(), rd_w.size()); end
    else for (int k = 0; k < 4; k++) begin
      total++;
      if (rd_a[k] !== AW'(10'h010 + k) || rd_w[k] !== AW'(10'h200 + k))
        begin bad++; $display("[TB] FAIL single_addr%0d: got A=%h W=%h, expected %h/%h", k, rd_a[k], rd_w[k], 10'h010 + k, 10'h200 + k); end
    end
    total++;
    if (rise_a != s + 6 || rise_w != s + 6)
      begin bad++; $display("[TB] FAIL single_latency: got A=%0d W=%0d, expected %0d", rise_a - s, rise_w - s, 6); end
    total++;
    if (cap_a.size() != 1 || cap_a[0] !== exp_beat(0, 10'h010, 0))
      begin bad++; $display("[TB] FAIL single_beat_A: got %0d beats or wrong lanes, expected 1 matching beat", cap_a.size()); end
    total++;
    if (cap_w.size() != 1 || cap_w[0] !== exp_beat(1, 10'h200, 0))
      begin bad++; $display("[TB] FAIL single_beat_W: got %0d beats or wrong lanes, expected 1 matching beat", cap_w.size()); end
    total++;
    if (done_q.size() != 1 || done_q[0] != s + 8 || done_busy_q[0] !== 1'b0)
      begin bad++; $display("[TB] FAIL single_done: got %0d pulses (first at +%0d), expected 1 at +8 with busy low",
                            done_q.size(), (done_q.size() > 0) ? done_q[0] - s : -1); end
    total++;
    if (!busy_seen) begin bad++; $display("[TB] FAIL single_busy: got o_busy never high, expected high"); end
  endtask

  task automatic test_throughput();
    int s;
    bit to;
    clear_logs();
    do_start(10'h0A0, 10'h150, 12'd3, s);
    run_until_done(200, 0, 0, -1, -1, to);
    total++;
    if (cap_a_edge.size() != 3)
      begin bad++; $display("[TB] FAIL tput_count: got %0d beats, expected 3", cap_a_edge.size()); end
    else for (int b = 0; b < 3; b++) begin
      total++;
      if (cap_a_edge[b] != s + 7 + 5 * b || cap_a[b] !== exp_beat(0, 10'h0A0, b))
        begin bad++; $display("[TB] FAIL tput_beat%0d: got edge +%0d, expected +%0d with matching lanes", b, cap_a_edge[b] - s, 7 + 5 * b); end
    end
  endtask

  task automatic test_stall_a();
    int s, n_early, last;
    bit to;
    clear_logs();
    do_start(10'h040, 10'h300, 12'd3, s);
    run_until_done(300, 0, 0, s + 5, s + 20, to);
    total++;
    if (to) begin bad++; $display("[TB] FAIL stall_timeout: got no o_done, expected one"); end
    n_early = 0;
    foreach (rd_a_edge[i]) if (rd_a_edge[i] <= s + 20) n_early++;
    total++;
    if (n_early != 4) begin bad++; $display("[TB] FAIL stall_reads: got %0d A reads while stalled, expected 4", n_early); end
    total++;
    if (cap_a.size() != 3 || cap_w.size() != 3)
      begin bad++; $display("[TB] FAIL stall_count: got A=%0d W=%0d, expected 3/3", cap_a.size(), cap_w.size()); end
    else begin
      for (int b = 0; b < 3; b++) begin
        total++;
        if (cap_a[b] !== exp_beat(0, 10'h040, b) || cap_w[b] !== exp_beat(1, 10'h300, b))
          begin bad++; $display("[TB] FAIL stall_beat%0d: got out-of-order or wrong lanes, expected base+4*%0d", b, b); end
      end
      total++;
      if (cap_w_edge[2] >= cap_a_edge[0])
        begin bad++; $display("[TB] FAIL stall_order: got W end +%0d, expected before A start +%0d", cap_w_edge[2] - s, cap_a_edge[0] - s); end
      last = cap_a_edge[2];
      total++;
      if (done_q.size() != 1 || done_q[0] != last + 1)
        begin bad++; $display("[TB] FAIL stall_done: got %0d pulses, expected 1 at +%0d", done_q.size(), last + 1 - s); end
    end
  endtask

  task automatic test_zero_beats();
    int s;
    bit to;
    clear_logs();
    do_start(10'h111, 10'h222, 12'd0, s);
    run_until_done(20, 0, 0, -1, -1, to);
    total++;
    if (done_q.size() != 1 || done_q[0] != s)
      begin bad++; $display("[TB] FAIL zero_done: got %0d pulses, expected 1 right after start", done_q.size()); end
    total++;
    if (rd_a.size() != 0 || rd_w.size() != 0 || busy_seen)
      begin bad++; $display("[TB] FAIL zero_idle: got reads=%0d/%0d busy=%0b, expected 0/0/0", rd_a.size(), rd_w.size(), busy_seen); end
  endtask

  task automatic test_wrap();
    int s;
    bit to;
    logic [AW-1:0] exp_addr [4];
    exp_addr[0] = 10'h3FE; exp_addr[1] = 10'h3FF; exp_addr[2] = 10'h000; exp_addr[3] = 10'h001;
    clear_logs();
    do_start(10'h3FE, 10'h010, 12'd1, s);
    run_until_done(100, 0, 0, -1, -1, to);
    total++;
    if (rd_a.size() != 4) begin bad++; $display("[TB] FAIL wrap_nreads: got %0d, expected 4", rd_a.size()); end
    else for (int k = 0; k < 4; k++) begin
      total++;
      if (rd_a[k] !== exp_addr[k]) begin bad++; $display("[TB] FAIL wrap_addr%0d: got %h, expected %h", k, rd_a[k], exp_addr[k]); end
    end
    total++;
    if (cap_a.size() != 1 || cap_a[0] !== exp_beat(0, 10'h3FE, 0))
      begin bad++; $display("[TB] FAIL wrap_beat: got %0d beats or wrong lanes, expected 1 wrapped beat", cap_a.size()); end
  endtask

  task automatic test_restart_ignored();
    int s;
    bit to;
    clear_logs();
    do_start(10'h060, 10'h160, 12'd2, s);
    repeat (3) begin @(posedge i_clk); #1; end
    i_base_A = 10'h300; i_base_W = 10'h301; i_num_beats = 12'd5; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    run_until_done(200, 20, 20, -1, -1, to);
    total++;
    if (rd_a.size() != 8 || rd_a[0] !== 10'h060 || rd_a[7] !== 10'h067)
      begin bad++; $display("[TB] FAIL restart_addr: got %0d reads, expected 8 from 0x060..0x067", rd_a.size()); end
    total++;
    if (cap_a.size() != 2 || cap_w.size() != 2 || done_q.size() != 1)
      begin bad++; $display("[TB] FAIL restart_count: got beats %0d/%0d dones %0d, expected 2/2/1", cap_a.size(), cap_w.size(), done_q.size()); end
  endtask

  task automatic test_reset_mid();
    int s;
    bit to;
    clear_logs();
    do_start(10'h080, 10'h180, 12'd2, s);
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    #1;
    total++;
    if ({o_busy, o_done, o_rd_en_A, o_rd_en_W, o_rd_addr_A, o_rd_addr_W, o_vld_A, o_vld_W,
         o_src_A_0, o_src_W_0} !== '0)
      begin bad++; $display("[TB] FAIL midreset_out: got nonzero outputs during reset, expected 0"); end
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    repeat (15) begin @(posedge i_clk); #1; end
    total++;
    if (done_q.size() != 0) begin bad++; $display("[TB] FAIL midreset_done: got %0d pulses, expected 0", done_q.size()); end
    clear_logs();
    do_start(10'h123, 10'h0AB, 12'd2, s);
    run_until_done(200, 0, 0, -1, -1, to);
    total++;
    if (cap_a.size() != 2 || cap_a[1] !== exp_beat(0, 10'h123, 1) || cap_w.size() != 2 || cap_w[1] !== exp_beat(1, 10'h0AB, 1) || done_q.size() != 1)
      begin bad++; $display("[TB] FAIL midreset_after: got beats %0d/%0d dones %0d, expected clean 2/2/1", cap_a.size(), cap_w.size(), done_q.size()); end
  endtask

  task automatic test_back_to_back();
    int s, n, last;
    bit to;
    logic [AW-1:0] ba, bw;
    for (int t = 0; t < 5; t++) begin
      ba = AW'($urandom);
      bw = AW'($urandom);
      n  = int'($urandom_range(4, 1));
      clear_logs();
      do_start(ba, bw, CNTW'(n), s);
      run_until_done(800, 40, 40, -1, -1, to);
      total++;
      if (to || cap_a.size() != n || cap_w.size() != n)
        begin bad++; $display("[TB] FAIL rand%0d_count: got beats %0d/%0d timeout=%0b, expected %0d", t, cap_a.size(), cap_w.size(), to, n); end
      else begin
        for (int b = 0; b < n; b++) begin
          total++;
          if (cap_a[b] !== exp_beat(0, ba, b) || cap_w[b] !== exp_beat(1, bw, b))
            begin bad++; $display("[TB] FAIL rand%0d_beat%0d: got wrong lanes, expected beat at base+%0d", t, b, 4 * b); end
        end
        for (int i = 0; i < rd_a.size(); i++) begin
          total++;
          if (rd_a[i] !== AW'((int'(ba) + i) % MEMN))
            begin bad++; $display("[TB] FAIL rand%0d_addr%0d: got %h, expected %h", t, i, rd_a[i], AW'((int'(ba) + i) % MEMN)); end
        end
        total++;
        if (rd_a.size() != 4 * n || rd_w.size() != 4 * n)
          begin bad++; $display("[TB] FAIL rand%0d_nreads: got %0d/%0d, expected %0d", t, rd_a.size(), rd_w.size(), 4 * n); end
        last = (cap_a_edge[n-1] > cap_w_edge[n-1]) ? cap_a_edge[n-1] : cap_w_edge[n-1];
        total++;
        if (done_q.size() != 1 || done_q[0] != last + 1 || done_busy_q[0] !== 1'b0)
          begin bad++; $display("[TB] FAIL rand%0d_done: got %0d pulses, expected 1 at edge %0d with busy low", t, done_q.size(), last + 1); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < MEMN; i++) begin
      mem_a[i] = {$urandom, $urandom, $urandom, $urandom};
      mem_w[i] = {$urandom, $urandom, $urandom, $urandom};
    end
    clear_logs();
    test_reset();
    test_single_beat();
    test_throughput();
    test_stall_a();
    test_zero_beats();
    test_wrap();
    test_restart_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no completion, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
